// File: rtl/keypad_decoder.sv
// -----------------------------------------------------------------------------
// keypad_decoder
//
// Turns the raw per-sample reports of a 4x4 keypad matrix scanner into one
// key event per physical press. A press is accepted after DEBOUNCE_HITS
// consistent reports of the same key. It is released after RELEASE_CYCLES
// cycles with no report at all, because the scanner only reports a held key
// while that key's column is being driven. Accepted presses are translated
// to calculator key values and queued in a 4-entry first-word-fall-through
// FIFO behind a valid/ready handshake.
//
// Parameters
//   RELEASE_CYCLES  quiet cycles before a key counts as released; must be
//                   longer than one full 4-column scan period (>= 2)
//   DEBOUNCE_HITS   matching reports needed to accept a press (1..255)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   row_index  in   [3:0] row of the reported key (0..3 legal)
//   col_index  in   [1:0] column of the reported key
//   key_valid  in   scanner sees a pressed key this cycle
//   ev_valid   out  FIFO head holds an event
//   ev_ready   in   consumer takes the head when high together with ev_valid
//   ev_key     out  [3:0] key value at the FIFO head (0 when empty)
//   ev_digit   out  head key is a decimal digit 0..9
//   overflow   out  sticky: an event was dropped on a full FIFO
// -----------------------------------------------------------------------------
module keypad_decoder #(
    parameter int RELEASE_CYCLES = 400000,
    parameter int DEBOUNCE_HITS  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_index,
    input  logic [1:0] col_index,
    input  logic       key_valid,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [3:0] ev_key,
    output logic       ev_digit,
    output logic       overflow
);

    localparam int               TMR_W      = $clog2(RELEASE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(RELEASE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [8:0]       HITS_TGT   = 9'(DEBOUNCE_HITS);
    localparam bit               SINGLE_HIT = (DEBOUNCE_HITS == 1);
    localparam int               FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    // Matrix position {row, col} to calculator key value.
    function automatic logic [3:0] key_map(input logic [3:0] code);
        logic [3:0] k;
        k = 4'd0;
        case (code)
            4'h0: k = 4'd1;
            4'h1: k = 4'd2;
            4'h2: k = 4'd3;
            4'h3: k = 4'd10;
            4'h4: k = 4'd4;
            4'h5: k = 4'd5;
            4'h6: k = 4'd6;
            4'h7: k = 4'd11;
            4'h8: k = 4'd7;
            4'h9: k = 4'd8;
            4'hA: k = 4'd9;
            4'hB: k = 4'd12;
            4'hC: k = 4'd14;
            4'hD: k = 4'd0;
            4'hE: k = 4'd15;
            4'hF: k = 4'd13;
            default: k = 4'd0;
        endcase
        return k;
    endfunction

    // ------------------------------------------------------------------
    // Sample qualification and release timer
    // ------------------------------------------------------------------
    logic             sample;
    logic [3:0]       raw_code;
    logic [TMR_W-1:0] timer_q;
    logic             timeout;

    // Reports with an out-of-range row are ignored entirely: they neither
    // count toward debounce nor keep a held key alive.
    assign sample   = key_valid && (row_index <= 4'd3);
    assign raw_code = {row_index[1:0], col_index};

    // Release fires on the cycle whose edge takes the timer to zero. A sample
    // on that same cycle reloads the timer instead, so no release occurs.
    assign timeout  = !sample && (timer_q <= TMR_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (sample) begin
            timer_q <= TMR_LOAD;
        end else if (timer_q != '0) begin
            timer_q <= timer_q - TMR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t     state_q;
    logic [3:0] cand_q;
    logic [7:0] hit_q;
    logic [8:0] hit_inc;
    logic       match;
    logic       push_evt;
    logic [3:0] push_key;
    logic       push_digit;

    assign hit_inc    = {1'b0, hit_q} + 9'd1;
    assign match      = (raw_code == cand_q);
    assign push_key   = key_map(raw_code);
    assign push_digit = (push_key <= 4'd9);

    // The event is generated on the edge that closes the final matching
    // sample, so the FIFO write happens in the same cycle as the FSM move
    // to HELD.
    always_comb begin
        push_evt = 1'b0;
        case (state_q)
            ST_IDLE: push_evt = sample && SINGLE_HIT;
            ST_ARM:  push_evt = sample && match && (hit_inc == HITS_TGT);
            default: push_evt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hit_q   <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sample) begin
                        hit_q   <= 8'd1;
                        state_q <= SINGLE_HIT ? ST_HELD : ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (sample) begin
                        if (match) begin
                            hit_q <= hit_inc[7:0];
                            if (push_evt) begin
                                state_q <= ST_HELD;
                            end
                        end else begin
                            // A different key restarts the count with the
                            // new key as candidate.
                            hit_q <= 8'd1;
                        end
                    end else if (timeout) begin
                        hit_q   <= 8'd0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_HELD: begin
                    // Held keys never repeat and never roll over to a second
                    // key; only a full quiet period ends the press.
                    if (timeout) begin
                        hit_q   <= 8'd0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    hit_q   <= 8'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Candidate code is pure data. Outside HELD every sample either becomes
    // the new candidate or equals the current one, so it can simply follow.
    always_ff @(posedge clk) begin
        if (sample && (state_q != ST_HELD)) begin
            cand_q <= raw_code;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO, first-word-fall-through
    // ------------------------------------------------------------------
    logic [4:0] fifo_mem [FIFO_DEPTH];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] fifo_cnt_q;
    logic       fifo_full;
    logic       pop;
    logic       push_ok;
    logic [4:0] head;

    assign fifo_full = (fifo_cnt_q == 3'd4);
    assign ev_valid  = (fifo_cnt_q != 3'd0);
    assign pop       = ev_valid && ev_ready;
    // A full FIFO still takes a new event when the head leaves this cycle.
    assign push_ok   = push_evt && (!fifo_full || pop);

    assign head      = fifo_mem[rd_ptr_q];
    assign ev_key    = ev_valid ? head[4:1] : 4'd0;
    assign ev_digit  = ev_valid && head[0];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= {push_key, push_digit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            fifo_cnt_q <= 3'd0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            fifo_cnt_q <= fifo_cnt_q + 3'(push_ok) - 3'(pop);
            if (push_evt && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_decoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_decoder
//
// Directed and randomized stimulus for keypad_decoder with RELEASE_CYCLES=8
// and DEBOUNCE_HITS=3. The reference model tracks presses by the timestamp of
// the last qualifying sample and keeps pending events in a queue.
// -----------------------------------------------------------------------------
module tb_keypad_decoder;

    localparam int RC = 8;
    localparam int DH = 3;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic [3:0] row_index = 4'd0;
    logic [1:0] col_index = 2'd0;
    logic       key_valid = 1'b0;
    logic       ev_ready  = 1'b0;
    logic       ev_valid;
    logic [3:0] ev_key;
    logic       ev_digit;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    keypad_decoder #(
        .RELEASE_CYCLES(RC),
        .DEBOUNCE_HITS (DH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_index(row_index),
        .col_index(col_index),
        .key_valid(key_valid),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_key   (ev_key),
        .ev_digit (ev_digit),
        .overflow (overflow)
    );

    // Reference model state
    logic [4:0] q[$];
    bit         m_ovf    = 1'b0;
    int         cyc      = 0;
    int         last_cyc = 0;
    bit         has_last = 1'b0;
    bit         pressed  = 1'b0;
    int         cand     = 0;
    int         hits     = 0;
    int         obs_pops = 0;
    int         key_tab[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model before the
    // edge, then advance the model across the edge.
    task automatic tick(input bit kv, input int r, input int c, input bit rdy);
        logic [4:0] hd;
        bit         pop;
        bit         push;
        bit         active;
        int         code;
        int         k;
        key_valid = kv;
        row_index = 4'(r);
        col_index = 2'(c);
        ev_ready  = rdy;
        @(negedge clk);
        check("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            hd = q[0];
            check("ev_key", 32'(ev_key), 32'(hd[4:1]));
            check("ev_digit", 32'(ev_digit), 32'(hd[0]));
        end
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (ev_valid && rdy) obs_pops++;

        pop  = (q.size() != 0) && rdy;
        push = 1'b0;
        code = r * 4 + c;
        if (kv && r >= 0 && r <= 3) begin
            active = has_last && ((cyc - last_cyc) < RC);
            if (!active) begin
                cand    = code;
                hits    = 1;
                pressed = (DH == 1);
                push    = (DH == 1);
            end else if (!pressed) begin
                if (code == cand) begin
                    hits++;
                    if (hits == DH) begin
                        push    = 1'b1;
                        pressed = 1'b1;
                    end
                end else begin
                    cand = code;
                    hits = 1;
                end
            end
            has_last = 1'b1;
            last_cyc = cyc;
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            k = key_tab[code];
            if (q.size() < 4) q.push_back({4'(k), (k <= 9)});
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0, rdy);
    endtask

    task automatic press(input int r, input int c, input bit rdy);
        for (int i = 0; i < DH; i++) tick(1'b1, r, c, rdy);
        idle(10, rdy);
    endtask

    // Asserts rst_n between edges so that exactly one rising edge sees it low.
    task automatic do_reset();
        key_valid = 1'b0;
        ev_ready  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf    = 1'b0;
        has_last = 1'b0;
        pressed  = 1'b0;
        hits     = 0;
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_ev_key", 32'(ev_key), 32'd0);
        check("rst_ev_digit", 32'(ev_digit), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int exp_d[4] = '{1, 2, 3, 10};
    int exp_e[4] = '{5, 6, 7, 8};
    int p0;
    int rr;
    int cc;
    int kr;
    int kc;
    int len;
    int gap;
    bit rb;
    bit kv;

    initial begin
        do_reset();
        idle(2, 1'b1);

        // Basic press: key 6 visible the cycle after the third sample
        for (int i = 0; i < 3; i++) tick(1'b1, 1, 2, 1'b1);
        check("basic_valid", 32'(ev_valid), 32'd1);
        check("basic_key", 32'(ev_key), 32'd6);
        check("basic_digit", 32'(ev_digit), 32'd1);
        idle(12, 1'b1);

        // Long hold of '*' with sparse reports, then a fresh press
        p0 = obs_pops;
        for (int i = 0; i < 100; i++) tick((i % 4) == 0, 3, 0, 1'b1);
        idle(10, 1'b1);
        check("hold_events", 32'(obs_pops - p0), 32'd1);
        press(3, 0, 1'b1);
        check("hold_second", 32'(obs_pops - p0), 32'd2);

        // Release boundary: samples 7 cycles after the last report keep the
        // key held; samples 8 cycles after start a fresh press.
        p0 = obs_pops;
        for (int i = 0; i < 3; i++) tick(1'b1, 0, 3, 1'b1);
        idle(6, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 0, 3, 1'b1);
        idle(7, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 0, 3, 1'b1);
        idle(3, 1'b1);
        check("release_edge", 32'(obs_pops - p0), 32'd2);
        idle(10, 1'b1);

        // Bounce between keys 1 and 2
        tick(1'b1, 0, 0, 1'b0);
        tick(1'b1, 0, 1, 1'b0);
        tick(1'b1, 0, 0, 1'b0);
        tick(1'b1, 0, 0, 1'b0);
        check("bounce_early", 32'(ev_valid), 32'd0);
        tick(1'b1, 0, 0, 1'b0);
        check("bounce_key", 32'(ev_key), 32'd1);
        tick(1'b0, 0, 0, 1'b1);
        idle(12, 1'b1);
        check("bounce_single", 32'(ev_valid), 32'd0);

        // Overflow: five presses with the consumer stalled
        press(0, 0, 1'b0);
        press(0, 1, 1'b0);
        press(0, 2, 1'b0);
        press(0, 3, 1'b0);
        press(1, 3, 1'b0);
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(ev_valid), 32'd1);
            check("drain_key", 32'(ev_key), 32'(exp_d[i]));
            tick(1'b0, 0, 0, 1'b1);
        end
        check("drain_empty", 32'(ev_valid), 32'd0);

        // Full FIFO with push and pop on the same edge
        do_reset();
        press(1, 0, 1'b0);
        press(1, 1, 1'b0);
        press(1, 2, 1'b0);
        press(2, 0, 1'b0);
        tick(1'b1, 2, 1, 1'b0);
        tick(1'b1, 2, 1, 1'b0);
        tick(1'b1, 2, 1, 1'b1);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("fullpp_valid", 32'(ev_valid), 32'd1);
            check("fullpp_key", 32'(ev_key), 32'(exp_e[i]));
            tick(1'b0, 0, 0, 1'b1);
        end
        check("fullpp_empty", 32'(ev_valid), 32'd0);
        idle(10, 1'b1);

        // Randomized bursts with bounce, illegal rows and random back-pressure
        for (int s = 0; s < 60; s++) begin
            kr  = int'($urandom_range(3, 0));
            kc  = int'($urandom_range(3, 0));
            len = int'($urandom_range(20, 4));
            gap = int'($urandom_range(12, 0));
            rb  = ($urandom_range(1, 0) == 1);
            for (int k = 0; k < len; k++) begin
                rr = kr;
                cc = kc;
                kv = ($urandom_range(1, 0) == 1);
                if ($urandom_range(7, 0) == 0) begin
                    rr = int'($urandom_range(15, 0));
                    cc = int'($urandom_range(3, 0));
                end
                tick(kv, rr, cc, rb ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0));
            end
            for (int k = 0; k < gap; k++) tick(1'b0, 0, 0, ($urandom_range(1, 0) == 1));
        end
        idle(12, 1'b1);

        // Reset mid-press with two queued events
        press(2, 2, 1'b0);
        press(3, 1, 1'b0);
        tick(1'b1, 3, 2, 1'b0);
        check("pre_rst_valid", 32'(ev_valid), 32'd1);
        do_reset();
        tick(1'b1, 3, 2, 1'b1);
        tick(1'b1, 3, 2, 1'b1);
        idle(12, 1'b1);
        check("post_rst_none", 32'(ev_valid), 32'd0);
        check("post_rst_ovf", 32'(overflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_decoder.md
# keypad_decoder

Consumes the raw per-sample key reports of the 4x4 keypad matrix scanner (row index, column index, key-valid strobe), debounces them, and emits exactly one key event per physical press. Events are translated to calculator key values and queued in a 4-entry FIFO behind a valid/ready handshake toward the calculator control logic. A press is recognised only after repeated consistent reports. Release is recognised only after a full scan period with no reports, because the scanner reports a held key only while that key's column is driven.

## Interface
- RELEASE_CYCLES, 400000: cycles without any key_valid before the key is considered released; must exceed one full 4-column scan period.
- DEBOUNCE_HITS, 16: matching key_valid samples required to accept a press; legal range 1..255.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- row_index  input  4  row of reported key; only 0..3 are legal.
- col_index  input  2  column of reported key.
- key_valid  input  1  high on each cycle the scanner sees a pressed key.
- ev_valid  output  1  FIFO head holds an event.
- ev_ready  input  1  consumer accepts head when high with ev_valid.
- ev_key  output  4  key value at FIFO head.
- ev_digit  output  1  head key is a decimal digit 0-9.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Sample qualification: a cycle is a sample when key_valid=1 and row_index<=3. key_valid=1 with row_index>3 counts as neither a sample nor a release-timer reload.
- Raw code: {row_index[1:0], col_index}.
- Key value map, by row in columns 0..3:
  - row0: 1, 2, 3, 10(A)
  - row1: 4, 5, 6, 11(B)
  - row2: 7, 8, 9, 12(C)
  - row3: 14(*), 0, 15(#), 13(D)
- ev_digit=1 iff ev_key<=9.
- Release timer: loaded with RELEASE_CYCLES-1 on every sample. Otherwise it decrements, saturating at 0. Width is $clog2(RELEASE_CYCLES).
- FSM states:
  - IDLE: on a sample, capture the candidate code, set hit count=1, go to ARM. If DEBOUNCE_HITS=1, push the event and go straight to HELD.
  - ARM:
    - Sample matching the candidate: increment hit count. Reaching DEBOUNCE_HITS pushes the event and goes to HELD.
    - Sample not matching: replace the candidate, set hit count=1, stay in ARM.
    - Timer reaching 0 with no sample this cycle: go to IDLE, no event.
  - HELD: samples of any code only reload the timer; no new events (no auto-repeat, no rollover). Timer reaching 0 with no sample goes to IDLE.
- FIFO: 4 entries of 5 bits (key, digit flag), first-word-fall-through. Head is visible on ev_key/ev_digit whenever ev_valid=1.
  - Pop happens when ev_valid&ev_ready.
  - Push succeeds when the FIFO is not full, or is full and a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow is set.
  - Count width is 3 bits; read and write pointers wrap modulo 4.
- overflow clears only on reset.

## Timing
- Reset values: FSM=IDLE, timer=0, hit count=0, FIFO empty, ev_valid=0, ev_key=0, ev_digit=0, overflow=0.
- Reset asserted mid-press or with a non-empty FIFO: all state clears immediately. The first event after reset needs a fresh full debounce.
- Press latency: event pushed on the edge closing the DEBOUNCE_HITS-th matching sample; ev_valid=1 in the following cycle.
- Release: reached RELEASE_CYCLES cycles after the last sample; FSM in IDLE from the next cycle.
- ev_key/ev_digit stay stable while ev_valid=1 and ev_ready=0.
- Empty FIFO with push: no same-cycle bypass; ev_valid rises the next cycle.
- Sample arriving on the cycle the timer would reach 0 reloads the timer; no release.

## Test plan
- Parameters RELEASE_CYCLES=8, DEBOUNCE_HITS=3. Three samples row=1,col=2, ev_ready=1 -> one event ev_key=6, ev_digit=1, ev_valid high one cycle after the third sample.
- Hold row=3,col=0 with samples every 4 cycles for 100 cycles, then stop -> exactly one event ev_key=14, ev_digit=0. FSM back in IDLE 8 cycles after the last sample. A new press then yields a second event.
- Bounce: samples at code (0,0),(0,1),(0,0),(0,0),(0,0) -> one event ev_key=1 after the fifth sample; no event for key 2.
- ev_ready=0 with 5 separate press/release cycles of keys 1,2,3,A,B -> FIFO holds 1,2,3,10, overflow=1. Then ev_ready=1 drains 1,2,3,10 in order, one per cycle.
- Full FIFO with simultaneous pop and push -> push accepted, count stays 4, overflow unchanged.
- rst_n low for 1 cycle during ARM and with 2 queued events -> ev_valid=0, overflow=0. A 2-sample partial press afterwards yields no event.
